// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared byte width and controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_BYTE_W = 8;

    typedef logic [1:0] uart_state_t;

    localparam logic [1:0] c_ST_IDLE       = 2'b00;
    localparam logic [1:0] c_ST_RUN        = 2'b01;
    localparam logic [1:0] c_ST_BREAK_HOLD = 2'b10;
    localparam logic [1:0] c_ST_FLUSH      = 2'b11;

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : First-word-fall-through receive buffer with level and flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [c_BYTE_W-1:0]           wr_data,
    output logic                          wr_accept,
    input  logic                          rd_en,
    output logic                          rd_valid,
    output logic [c_BYTE_W-1:0]           rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0] c_FULL = (c_AW+1)'(FIFO_DEPTH);

    logic [c_BYTE_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW-1:0]     r_rd_ptr;
    logic [c_AW:0]       r_level;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;
    logic                w_push;

    assign w_full  = (r_level == c_FULL);
    assign w_empty = (r_level == '0);
    assign w_pop   = rd_en && !w_empty && !flush;
    // A pop frees a slot in the same cycle, so a full buffer still takes the write
    assign w_push  = wr_en && (!w_full || w_pop) && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    assign wr_accept = w_push;
    assign rd_valid  = !w_empty;
    assign rd_data   = w_empty ? '0 : r_mem[r_rd_ptr];
    assign level     = r_level;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_ctrl
//  Description : UART receive controller: state machine, overrun/break flags,
//                buffered consumer stream. Define UART_RX_CTRL_STATS_EN for
//                saturating byte/break counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          ctrl_en,
    input  logic                          ctrl_flush,
    output logic                          uart_rx_en,
    input  logic                          uart_rx_break,
    input  logic                          uart_rx_valid,
    input  logic [c_BYTE_W-1:0]           uart_rx_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [c_BYTE_W-1:0]           out_data,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overrun,
    input  logic                          overrun_clr,
    output logic                          break_seen,
    output logic [15:0]                   byte_count,
    output logic [7:0]                    break_count
);

    uart_state_t r_state;
    uart_state_t w_state_nxt;
    logic        r_overrun;
    logic        r_break_seen;
    logic        w_in_run;
    logic        w_wr_req;
    logic        w_wr_accept;
    logic        w_flush;
    logic        w_brk_entry;

    assign w_in_run    = (r_state == c_ST_RUN);
    // Flush outranks break, which outranks the byte strobe
    assign w_wr_req    = w_in_run && uart_rx_valid && !ctrl_flush && !uart_rx_break;
    assign w_flush     = (w_in_run && ctrl_flush) || (r_state == c_ST_FLUSH);
    assign w_brk_entry = w_in_run && !ctrl_flush && uart_rx_break;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (ctrl_en) w_state_nxt = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (ctrl_flush)         w_state_nxt = c_ST_FLUSH;
                else if (uart_rx_break) w_state_nxt = c_ST_BREAK_HOLD;
                else if (!ctrl_en)      w_state_nxt = c_ST_IDLE;
            end
            c_ST_BREAK_HOLD: begin
                if (!uart_rx_break) w_state_nxt = ctrl_en ? c_ST_RUN : c_ST_IDLE;
            end
            default: begin
                w_state_nxt = ctrl_en ? c_ST_RUN : c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= c_ST_IDLE;
            r_overrun    <= 1'b0;
            r_break_seen <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            // A fresh overrun in the clear cycle keeps the flag set
            r_overrun    <= (w_wr_req && !w_wr_accept) || (r_overrun && !overrun_clr);
            r_break_seen <= w_brk_entry;
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (w_flush),
        .wr_en     (w_wr_req),
        .wr_data   (uart_rx_data),
        .wr_accept (w_wr_accept),
        .rd_en     (out_ready),
        .rd_valid  (out_valid),
        .rd_data   (out_data),
        .level     (level)
    );

    assign uart_rx_en = (r_state != c_ST_IDLE);
    assign overrun    = r_overrun;
    assign break_seen = r_break_seen;

`ifdef UART_RX_CTRL_STATS_EN
    logic [15:0] r_byte_count;
    logic [7:0]  r_break_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_byte_count  <= '0;
            r_break_count <= '0;
        end else begin
            if (w_wr_accept && (r_byte_count != '1))  r_byte_count  <= r_byte_count + 1'b1;
            if (w_brk_entry && (r_break_count != '1)) r_break_count <= r_break_count + 1'b1;
        end
    end

    assign byte_count  = r_byte_count;
    assign break_count = r_break_count;
`else
    assign byte_count  = '0;
    assign break_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_ctrl
//  Description : Directed self-checking bench for uart_rx_ctrl (FIFO_DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ctrl;

    logic        clk;
    logic        resetn;
    logic        ctrl_en;
    logic        ctrl_flush;
    logic        uart_rx_en;
    logic        uart_rx_break;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [2:0]  level;
    logic        overrun;
    logic        overrun_clr;
    logic        break_seen;
    logic [15:0] byte_count;
    logic [7:0]  break_count;

    int n_chk;
    int n_err;
    int n_brk;

    uart_rx_ctrl #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .ctrl_en       (ctrl_en),
        .ctrl_flush    (ctrl_flush),
        .uart_rx_en    (uart_rx_en),
        .uart_rx_break (uart_rx_break),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .level         (level),
        .overrun       (overrun),
        .overrun_clr   (overrun_clr),
        .break_seen    (break_seen),
        .byte_count    (byte_count),
        .break_count   (break_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        tick();
        uart_rx_valid = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        resetn = 1'b0; ctrl_en = 1'b0; ctrl_flush = 1'b0; uart_rx_break = 1'b0;
        uart_rx_valid = 1'b0; uart_rx_data = '0; out_ready = 1'b0; overrun_clr = 1'b0;
        tick(); tick();

        check("rst_rx_en",     32'(uart_rx_en),  0);
        check("rst_out_valid", 32'(out_valid),   0);
        check("rst_out_data",  32'(out_data),    0);
        check("rst_level",     32'(level),       0);
        check("rst_overrun",   32'(overrun),     0);
        check("rst_break_seen",32'(break_seen),  0);
        check("rst_byte_cnt",  32'(byte_count),  0);
        check("rst_break_cnt", 32'(break_count), 0);

        resetn = 1'b1;
        tick();
        check("idle_rx_en", 32'(uart_rx_en), 0);
        ctrl_en = 1'b1;
        tick();
        check("run_rx_en", 32'(uart_rx_en), 1);

        // Basic pass-through with simultaneous push/pop
        out_ready = 1'b1;
        send_byte(8'h41);
        check("b1_level", 32'(level), 1);
        check("b1_valid", 32'(out_valid), 1);
        check("b1_data",  32'(out_data), 32'h41);
        send_byte(8'h31);
        check("b2_level", 32'(level), 1);
        check("b2_data",  32'(out_data), 32'h31);
        tick();
        check("b_empty_level", 32'(level), 0);
        check("b_empty_valid", 32'(out_valid), 0);

        // Fill past capacity with consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            uart_rx_valid = 1'b1;
            uart_rx_data  = 8'h61 + 8'(i);
            tick();
            if (i == 3) check("ov_pre", 32'(overrun), 0);
        end
        uart_rx_valid = 1'b0;
        check("ov_level", 32'(level), 4);
        check("ov_flag",  32'(overrun), 1);
        check("ov_hold",  32'(out_data), 32'h61);
        overrun_clr = 1'b1;
        send_byte(8'h66);
        check("ov_clr_vs_new", 32'(overrun), 1);
        tick();
        overrun_clr = 1'b0;
        check("ov_clr", 32'(overrun), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ov_drain", 32'(out_data), 32'h61 + i);
            tick();
        end
        check("ov_drain_level", 32'(level), 0);

        // Full buffer write coinciding with a pop
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(8'h70 + 8'(i));
        out_ready = 1'b1;
        send_byte(8'h74);
        check("fullpop_level",   32'(level), 4);
        check("fullpop_overrun", 32'(overrun), 0);
        for (int i = 0; i < 4; i++) begin
            check("fullpop_drain", 32'(out_data), 32'h71 + i);
            tick();
        end
        check("fullpop_empty", 32'(out_valid), 0);

        // Break held 20 cycles with a stray zero byte
        n_brk = 0;
        uart_rx_break = 1'b1;
        for (int i = 0; i < 20; i++) begin
            uart_rx_valid = (i == 10);
            uart_rx_data  = 8'h00;
            tick();
            if (break_seen) n_brk++;
        end
        uart_rx_valid = 1'b0;
        uart_rx_break = 1'b0;
        check("brk_pulses", 32'(n_brk), 1);
        check("brk_level",  32'(level), 0);
        tick();
        out_ready = 1'b0;
        send_byte(8'h55);
        check("brk_run_level", 32'(level), 1);
        check("brk_run_data",  32'(out_data), 32'h55);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Flush with three bytes buffered
        for (int i = 0; i < 3; i++) send_byte(8'h80 + 8'(i));
        check("fl_pre_level", 32'(level), 3);
        ctrl_flush = 1'b1;
        tick();
        ctrl_flush = 1'b0;
        check("fl_level", 32'(level), 0);
        check("fl_valid", 32'(out_valid), 0);
        tick();
        send_byte(8'h99);
        check("fl_run_level", 32'(level), 1);
        check("fl_run_data",  32'(out_data), 32'h99);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Disable with two bytes buffered; they still drain
        send_byte(8'hA1);
        send_byte(8'hA2);
        ctrl_en = 1'b0;
        tick();
        check("dis_rx_en", 32'(uart_rx_en), 0);
        send_byte(8'hA3);
        check("dis_level", 32'(level), 2);
        out_ready = 1'b1;
        check("dis_d0", 32'(out_data), 32'hA1);
        tick();
        check("dis_d1", 32'(out_data), 32'hA2);
        tick();
        check("dis_empty", 32'(level), 0);

        // Reset mid-drain discards contents
        ctrl_en = 1'b1;
        out_ready = 1'b0;
        tick();
        send_byte(8'hB1);
        send_byte(8'hB2);
        check("mr_pre_level", 32'(level), 2);
        resetn = 1'b0;
        #1;
        check("mr_level", 32'(level), 0);
        check("mr_valid", 32'(out_valid), 0);
        tick();
        resetn = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr_no_emit", 32'(out_valid), 0);
        end

        // Statistics: 9 bytes and 2 breaks
        for (int i = 0; i < 9; i++) send_byte(8'(i));
        for (int k = 0; k < 2; k++) begin
            uart_rx_break = 1'b1;
            tick(); tick();
            uart_rx_break = 1'b0;
            tick(); tick();
        end
`ifdef UART_RX_CTRL_STATS_EN
        check("st_bytes",  32'(byte_count),  9);
        check("st_breaks", 32'(break_count), 2);
`else
        check("st_bytes",  32'(byte_count),  0);
        check("st_breaks", 32'(break_count), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, receive buffer entries; power of 2, range 2..16.
REQ-002 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port resetn  in  1  asynchronous active-low reset.
REQ-004 SHALL have port ctrl_en  in  1  controller enable; 0 parks receiver.
REQ-005 SHALL have port ctrl_flush  in  1  single-cycle pulse; discard buffer contents.
REQ-006 SHALL have port uart_rx_en  out  1  enable to the UART receiver.
REQ-007 SHALL have port uart_rx_break  in  1  receiver break indication.
REQ-008 SHALL have port uart_rx_valid  in  1  receiver byte strobe, one cycle per byte.
REQ-009 SHALL have port uart_rx_data  in  8  received byte, qualified by uart_rx_valid.
REQ-010 SHALL have ports out_valid out 1, out_ready in 1, out_data out 8: consumer stream.
REQ-011 SHALL have port level  out  $clog2(FIFO_DEPTH)+1  current buffer occupancy.
REQ-012 SHALL have ports overrun out 1 (sticky) and overrun_clr in 1 (pulse).
REQ-013 SHALL have port break_seen  out  1  one-cycle pulse on each accepted break.
REQ-014 SHALL have ports byte_count out 16 and break_count out 8 (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, RUN, BREAK_HOLD, FLUSH.
REQ-016 IDLE: uart_rx_en=0; ctrl_en=1 -> RUN next cycle.
REQ-017 RUN: uart_rx_en=1; ctrl_en=0 -> IDLE; uart_rx_break=1 -> BREAK_HOLD; ctrl_flush=1 -> FLUSH.
REQ-018 Priority in RUN, same cycle: ctrl_flush > uart_rx_break > ctrl_en=0.
REQ-019 BREAK_HOLD: uart_rx_en=1, bytes ignored; break_seen pulses on entry cycle; exit to RUN when uart_rx_break=0 (IDLE if ctrl_en=0).
REQ-020 FLUSH: lasts exactly one cycle; buffer emptied, level=0, out_valid=0; then RUN if ctrl_en=1, else IDLE.
REQ-021 In RUN, uart_rx_valid=1 with buffer not full -> byte written; level updates next cycle.
REQ-022 uart_rx_valid=1 with buffer full -> byte dropped, overrun set next cycle, buffer unchanged.
REQ-023 Full-buffer write and pop in same cycle -> write accepted; no overrun.
REQ-024 Stream SHALL be first-word-fall-through: out_valid=(level!=0); out_data = oldest byte; pop when out_valid&&out_ready.
REQ-025 Write to empty buffer SHALL give out_valid=1 the following cycle (latency 1).
REQ-026 Simultaneous push and pop SHALL leave level unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-027 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 overrun_clr clears overrun; a coincident new overrun wins (overrun stays 1).
REQ-029 Bytes in buffer SHALL remain drainable in IDLE and BREAK_HOLD.

Reset
REQ-030 On resetn=0: state IDLE, uart_rx_en=0, out_valid=0, out_data=0, level=0, overrun=0, break_seen=0, byte_count=0, break_count=0.
REQ-031 Reset mid-frame or mid-drain SHALL discard buffer contents; no byte emitted after release until a new write.

Configuration
REQ-032 Macro UART_RX_CTRL_STATS_EN defined: byte_count increments per accepted byte, break_count per BREAK_HOLD entry, both saturating at all-ones.
REQ-033 Macro undefined: byte_count and break_count ports present, driven constant 0, no counter flops.

Structure
REQ-034 Shared package uart_pkg SHALL hold FSM state typedef (2-bit encoding) and byte width constant (8).
REQ-035 Buffer SHALL be sub-module uart_rx_fifo (storage, pointers, level, flush); FSM and flags in uart_rx_ctrl.

Verification
REQ-036 ctrl_en=1, bytes 0x41,0x31 at uart_rx_valid, out_ready=1 -> out_data 0x41 then 0x31, level returns 0.
REQ-037 out_ready=0, FIFO_DEPTH=4, write 5 bytes 0x61..0x65 -> level=4, overrun=1, drained 0x61..0x64.
REQ-038 uart_rx_break=1 for 20 cycles with byte 0x00 strobed -> one break_seen pulse, byte not buffered, back to RUN.
REQ-039 Buffer at 3, ctrl_flush pulse -> level=0 next cycle, out_valid=0, state RUN.
REQ-040 ctrl_en=0 with 2 bytes buffered -> uart_rx_en=0 next cycle, both bytes still drain.
REQ-041 With UART_RX_CTRL_STATS_EN, 9 bytes + 2 breaks -> byte_count=9, break_count=2; without: both 0.
